// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framer: FSM state encoding,
// default framing constants and a small width helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE    = 8'hA5;
  localparam int unsigned DEF_TIMEOUT_CLKS = 104160;

  // Address width for a buffer of n entries; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload store for the command framer: DEPTH x 8 register array with one
// synchronous write port and an asynchronous read port. Not reset.
module uart_cmd_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses return zero rather than indexing past the array.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/uart_cmd_parser.sv
// Receive-side command framer: SYNC, LEN, payload, CSUM with hold/release
// handoff. Optional inter-byte timeout enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter  int unsigned MAX_LEN      = 16,
  parameter  logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter  int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1),
  localparam int unsigned AW           = addr_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_new,
  output logic             frame_valid,
  output logic [LEN_W-1:0] frame_len,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  input  logic             frame_ready,
  output logic             err_csum,
  output logic             err_len,
  output logic             err_overrun,
  output logic             err_timeout
);

  state_t        state;
  logic [7:0]    acc;
  logic [AW-1:0] idx;
  logic [7:0]    sum_c;
  logic          len_ok;
  logic          last_byte;
  logic          buf_we;
  logic          timeout_hit;

  assign sum_c     = acc + rx_data;
  assign len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MAX_LEN);
  assign last_byte = (LEN_W'(idx) == (frame_len - LEN_W'(1)));
  assign buf_we    = rx_new && (state == ST_PAYLOAD);

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [TW-1:0] timer;
  logic          counting;

  assign counting    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign timeout_hit = counting && !rx_new && (timer == TW'(TIMEOUT_CLKS - 1));

  // Idle timer: runs only inside a partial frame, restarts on every byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (!counting || rx_new || timeout_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Framing FSM with registered handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      acc         <= 8'd0;
      idx         <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
      if (timeout_hit) begin
        state <= ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (rx_new && (rx_data == SYNC_BYTE)) begin
              acc   <= 8'd0;
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_new) begin
              if (len_ok) begin
                frame_len <= LEN_W'(rx_data);
                acc       <= rx_data;
                idx       <= '0;
                state     <= ST_PAYLOAD;
              end else begin
                err_len <= 1'b1;
                state   <= ST_HUNT;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_new) begin
              acc <= sum_c;
              idx <= idx + AW'(1);
              if (last_byte) begin
                state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (rx_new) begin
              if (sum_c == 8'd0) begin
                frame_valid <= 1'b1;
                state       <= ST_HOLD;
              end else begin
                err_csum <= 1'b1;
                state    <= ST_HUNT;
              end
            end
          end
          ST_HOLD: begin
            if (rx_new) begin
              err_overrun <= 1'b1;
            end
            if (frame_ready) begin
              frame_valid <= 1'b0;
              state       <= ST_HUNT;
            end
          end
          default: begin
            state <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected events,
// a monitor pops and checks them as the DUT produces them.
module tb_uart_cmd_parser;

  localparam int MAXL     = 16;
  localparam int TMO_CLKS = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam int EV_NONE  = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_FALL  = 2;
  localparam int EV_CSUM  = 3;
  localparam int EV_LEN   = 4;
  localparam int EV_OVR   = 5;
  localparam int EV_TMO   = 6;

  typedef struct {
    int         kind;
    int         at;
    int         len;
    logic [7:0] pl [MAXL];
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_new;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ready;
  logic       err_csum, err_len, err_overrun, err_timeout;

  exp_t       q[$];
  logic [7:0] cur_pl [MAXL];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         held_len = 0;

  uart_cmd_parser #(
    .MAX_LEN      (MAXL),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (TMO_CLKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_new      (rx_new),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int gap();
    return int'($urandom_range(0, 2));
  endfunction

  task automatic push_ev(input int kind, input int at, input int len);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    e.len  = len;
    e.pl   = cur_pl;
    q.push_back(e);
  endtask

  // One byte strobe presented at a negedge, sampled by the next posedge.
  task automatic send(input logic [7:0] b, input int g);
    rx_data = b;
    rx_new  = 1'b1;
    @(negedge clk);
    rx_new  = 1'b0;
    rx_data = 8'($urandom);
    repeat (g) @(negedge clk);
  endtask

  // Full frame; cxor != 0 corrupts the checksum. Payload taken from cur_pl.
  task automatic send_frame(input int len, input logic [7:0] cxor, input bit rand_pl);
    logic [7:0] s;
    if (rand_pl) for (int i = 0; i < len; i++) cur_pl[i] = 8'($urandom);
    send(SYNC, gap());
    s = 8'(len);
    send(8'(len), gap());
    for (int i = 0; i < len; i++) begin
      s = s + cur_pl[i];
      send(cur_pl[i], gap());
    end
    push_ev((cxor == 8'd0) ? EV_FRAME : EV_CSUM, cyc + 1, len);
    send((8'd0 - s) ^ cxor, 0);
  endtask

  task automatic send_bad_len(input logic [7:0] lb);
    send(SYNC, gap());
    push_ev(EV_LEN, cyc + 1, 0);
    send(lb, gap());
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h5A;
      send(b, gap());
    end
  endtask

  // While a frame is held: optional overrun bytes, then release.
  task automatic release_frame(input int novr, input bit ovr_with_ready);
    for (int i = 0; i < novr; i++) begin
      push_ev(EV_OVR, cyc + 1, 0);
      send(8'($urandom), gap());
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (ovr_with_ready) begin
      push_ev(EV_OVR, cyc + 1, 0);
      rx_data = 8'($urandom);
      rx_new  = 1'b1;
    end
    push_ev(EV_FALL, cyc + 1, 0);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    rx_new      = 1'b0;
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", kind, EV_NONE);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.at);
    if (kind == EV_FRAME && e.kind == EV_FRAME) begin
      chk("frame_len", int'(frame_len), e.len);
      held_len = e.len;
      for (int i = 0; i < e.len; i++) begin
        rd_addr = 4'(i);
        #1;
        chk("rd_data", int'(rd_data), int'(e.pl[i]));
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_frame_len", int'(frame_len), 0);
    chk("rst_err_csum", int'(err_csum), 0);
    chk("rst_err_len", int'(err_len), 0);
    chk("rst_err_overrun", int'(err_overrun), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
  endtask

  initial begin : monitor
    bit pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (err_csum)    take(EV_CSUM);
        if (err_len)     take(EV_LEN);
        if (err_overrun) take(EV_OVR);
        if (err_timeout) take(EV_TMO);
        if (frame_valid && !pv) take(EV_FRAME);
        else if (frame_valid) chk("len_stable", int'(frame_len), held_len);
        if (!frame_valid && pv) take(EV_FALL);
        pv = frame_valid;
      end
    end
  end

  initial begin : watchdog
    #2500000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int kind;
    rst_n = 1'b0; rx_data = 8'h00; rx_new = 1'b0; frame_ready = 1'b0; rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Reference frame 03 11 22 33 with its correct checksum.
    cur_pl[0] = 8'h11; cur_pl[1] = 8'h22; cur_pl[2] = 8'h33;
    send_frame(3, 8'h00, 1'b0);
    release_frame(0, 1'b0);
    // Same frame with CSUM 0x88, then a good frame.
    send_frame(3, 8'h1F, 1'b0);
    send_frame(5, 8'h00, 1'b1);
    release_frame(0, 1'b0);
    // Length errors, including a SYNC value in the LEN slot.
    send_bad_len(8'h00);
    send_bad_len(8'h11);
    send_bad_len(SYNC);
    // Leading garbage then a frame of maximum length.
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 1);
    send_frame(MAXL, 8'h00, 1'b1);
    release_frame(2, 1'b0);
    // Overrun in the release cycle, then back-to-back next frame.
    send_frame(1, 8'h00, 1'b1);
    release_frame(0, 1'b1);
    send_frame(2, 8'h00, 1'b1);
    release_frame(1, 1'b0);

    // Stalled partial frame: A5 02 11 then idle.
    send(SYNC, 0);
    send(8'h02, 0);
`ifdef UART_CMD_TIMEOUT_EN
    push_ev(EV_TMO, cyc + 1 + TMO_CLKS, 0);
`endif
    send(8'h11, 0);
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-payload discards the partial frame silently.
    send(SYNC, 0); send(8'h04, 0); send(8'hAA, 0); send(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(4, 8'h00, 1'b1);
    release_frame(0, 1'b0);

    // Reset while a frame is held.
    send_frame(6, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic mix.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          send_frame(int'($urandom_range(1, MAXL)), 8'h00, 1'b1);
          release_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        1: send_frame(int'($urandom_range(1, MAXL)), 8'($urandom_range(1, 255)), 1'b1);
        2: send_bad_len(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
        default: send_garbage(int'($urandom_range(1, 5)));
      endcase
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("events_pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
